// File: rtl/mux_scan_ctrl.sv
// Sequential scanner for a 16:1 bit mux: steps sel 0..15, settles, samples mux_out into result.
// Optional MUX_SCAN_SKIP_EN: masked channels are skipped instead of being visited.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] mask,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  ch_q, ch_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] result_q, result_d;
  logic        rv_q, rv_d;

`ifdef MUX_SCAN_SKIP_EN
  // Returns {found, index} of the lowest set bit.
  function automatic logic [4:0] first_set(input logic [15:0] v);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (v[i-1]) r = {1'b1, 4'(i - 1)};
    end
    return r;
  endfunction

  logic [4:0] first_en;
  logic [4:0] next_en;
  assign first_en = first_set(mask);
  assign next_en  = first_set(mask_q & (16'hFFFF << ({1'b0, ch_q} + 5'd1)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    result_d = result_q;
    rv_d     = rv_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d   = mask;
          result_d = '0;
          rv_d     = 1'b0;
          cnt_d    = SETTLE_CNT;
`ifdef MUX_SCAN_SKIP_EN
          if (first_en[4]) begin
            ch_d    = first_en[3:0];
            state_d = SCAN;
          end else begin
            // Empty mask: nothing to visit, the scan completes immediately.
            ch_d    = '0;
            rv_d    = 1'b1;
            state_d = DONE;
          end
`else
          ch_d    = '0;
          state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          ch_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d[ch_q] = mux_out & mask_q[ch_q];
`ifdef MUX_SCAN_SKIP_EN
          if (next_en[4]) begin
            ch_d  = next_en[3:0];
            cnt_d = SETTLE_CNT;
          end else begin
            state_d = DONE;
            rv_d    = 1'b1;
          end
`else
          if (ch_q == 4'd15) begin
            state_d = DONE;
            rv_d    = 1'b1;
          end else begin
            ch_d  = ch_q + 4'd1;
            cnt_d = SETTLE_CNT;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        ch_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel          = (state_q == SCAN) ? ch_q : '0;
  assign busy         = (state_q == SCAN);
  assign done         = (state_q == DONE);
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: models the 16:1 mux and scoreboards each scan.
module tb_mux_scan_ctrl;
  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] mask;
  logic [15:0] src;
  logic        mux_out;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        result_valid;

  int passed = 0;
  int total  = 0;

  logic [15:0] exp_res_q[$];
  int          exp_lat_q[$];

  always #5 clk = ~clk;

  assign mux_out = src[sel];

  mux_scan_ctrl #(.SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .mask         (mask),
    .mux_out      (mux_out),
    .sel          (sel),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = '0; src = '0;
    #12;
    total++; if ({sel, busy, done, result, result_valid} !== 23'd0)
      $display("FAIL reset_outputs: got sel=%0d busy=%b done=%b result=%h rv=%b, want all 0",
               sel, busy, done, result, result_valid);
    else passed++;
    #10 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Starts a scan, pushes the expected outcome, then follows it cycle by cycle until done.
  task automatic do_scan(input logic [15:0] s, input logic [15:0] m, input string nm);
    int          chans[$];
    logic [15:0] er;
    int          lat;
    bit          seen;
    src  = s;
    mask = m;
    for (int i = 0; i < 16; i++) begin
`ifdef MUX_SCAN_SKIP_EN
      if (m[i]) chans.push_back(i);
`else
      chans.push_back(i);
`endif
    end
    exp_res_q.push_back(s & m);
    exp_lat_q.push_back(chans.size() * (SETTLE + 1));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    er = '0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0 && chans.size() > 0) begin
        total++; if (result_valid !== 1'b0 || result !== 16'h0)
          $display("FAIL %s_cleared: got rv=%b result=%h, want rv=0 result=0000", nm, result_valid, result);
        else passed++;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        er  = exp_res_q.pop_front();
        lat = exp_lat_q.pop_front();
        total++; if (result !== er)
          $display("FAIL %s_result: got %h, want %h", nm, result, er);
        else passed++;
        total++; if (k != lat)
          $display("FAIL %s_latency: done at T+%0d, want T+%0d", nm, k, lat);
        else passed++;
        total++; if (result_valid !== 1'b1 || busy !== 1'b0)
          $display("FAIL %s_done_flags: got rv=%b busy=%b, want rv=1 busy=0", nm, result_valid, busy);
        else passed++;
      end else begin
        total++;
        if (k / (SETTLE + 1) >= chans.size())
          $display("FAIL %s_overrun: still scanning at T+%0d, sel=%0d", nm, k, sel);
        else if (busy !== 1'b1 || sel !== 4'(chans[k / (SETTLE + 1)]))
          $display("FAIL %s_sel_t%0d: got busy=%b sel=%0d, want busy=1 sel=%0d",
                   nm, k, busy, sel, chans[k / (SETTLE + 1)]);
        else passed++;
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL %s_timeout: no done within 200 cycles", nm);
      void'(exp_res_q.pop_front());
      void'(exp_lat_q.pop_front());
    end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || sel !== 4'd0 || result_valid !== 1'b1 || result !== er)
      $display("FAIL %s_hold: got done=%b busy=%b sel=%0d rv=%b result=%h, want 0 0 0 1 %h",
               nm, done, busy, sel, result_valid, result, er);
    else passed++;
  endtask

  task automatic test_full_scan();
    do_scan(16'hA5C3, 16'hFFFF, "full");
  endtask

  task automatic test_masked_scan();
    do_scan(16'hA5C3, 16'h00F0, "masked");
  endtask

  task automatic test_empty_mask();
    do_scan(16'hA5C3, 16'h0000, "empty");
  endtask

  task automatic test_abort_busy_start();
    bit saw_done;
    src = 16'hA5C3; mask = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) begin
        total++; if (busy !== 1'b1 || sel !== 4'd2 || result !== 16'h0003)
          $display("FAIL busy_start_ignored: got busy=%b sel=%0d result=%h, want 1 2 0003", busy, sel, result);
        else passed++;
      end
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (k == 9) abort = 1'b1;
      if (k == 10) abort = 1'b0;
    end
    total++; if (busy !== 1'b0 || sel !== 4'd0 || done !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL abort_state: got busy=%b sel=%0d done=%b rv=%b, want 0 0 0 0", busy, sel, done, result_valid);
    else passed++;
    saw_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done || result !== 16'h0003 || result_valid !== 1'b0)
      $display("FAIL abort_after: got activity=%b result=%h rv=%b, want 0 0003 0", saw_done, result, result_valid);
    else passed++;
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || sel !== 4'd0 || result !== 16'h0003)
      $display("FAIL start_abort_idle: got busy=%b done=%b sel=%0d result=%h, want 0 0 0 0003",
               busy, done, sel, result);
    else passed++;
  endtask

  task automatic test_async_reset();
    src = 16'hA5C3; mask = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({sel, busy, done, result, result_valid} !== 23'd0)
      $display("FAIL async_reset: got sel=%0d busy=%b done=%b result=%h rv=%b, want all 0",
               sel, busy, done, result, result_valid);
    else passed++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_scan(16'hA5C3, 16'hFFFF, "post_reset");
  endtask

  task automatic test_rescan();
    do_scan(16'hA5C3, 16'hFFFF, "rescan1");
    do_scan(16'h1234, 16'hFFFF, "rescan2");
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_masked_scan();
    test_empty_mask();
    test_abort_busy_start();
    test_start_abort_idle();
    test_async_reset();
    test_rescan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential channel scanner that drives the 4-bit select of the 16:1 bit multiplexer and captures its single-bit output. On a start request it steps the select through all 16 channels, waits a programmable settle time on each, and samples the mux output into a 16-bit result word. It sits directly upstream of the 16:1 mux on `sel` and directly downstream of it on `out`, turning the mux into a parallel snapshot of 16 sources.

## Interface
- SETTLE, 2, idle cycles held on each channel before sampling (range 0–15)
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  scan request; accepted only in IDLE
- abort  input  1  synchronous scan cancel
- mask  input  16  channel enable; latched on start acceptance
- mux_out  input  1  output of the 16:1 mux
- sel  output  4  select driven to the 16:1 mux
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse at scan completion
- result  output  16  captured bits; `result[n]` is the sample taken with `sel == n`
- result_valid  output  1  result holds a complete scan

## Operation
- States: IDLE, SCAN, DONE.
- Reset, asynchronous: state IDLE; `sel`=0, `busy`=0, `done`=0, `result`=0, `result_valid`=0, counter=0, latched mask=0.
- IDLE, start=1 and abort=0:
  - latch `mask`
  - clear `result` and `result_valid`
  - load the first channel into `ch`, load `cnt`=SETTLE
  - go to SCAN
- SCAN: `sel`=`ch`, `busy`=1. Each cycle:
  - if `cnt`≠0: decrement `cnt`
  - else: write `result[ch]` = `mux_out` & `mask_q[ch]`, then advance to the next channel with `cnt`=SETTLE, or go to DONE after the last channel.
- DONE: `done`=1 for exactly one cycle, `result_valid`←1, `busy`=0, `sel`←0, then return to IDLE.
- abort=1 in SCAN: go to IDLE next cycle. `busy`=0, `sel`=0, no `done`, `result_valid` stays 0, partial `result` retained. abort has no effect in IDLE or DONE.
- start while in SCAN or DONE is ignored. It is not queued.
- If start and abort are both high in IDLE, abort wins and the scan does not start.
- Channel order is ascending, 0→15. There is no wrap: the scan ends after the last channel.
- `result` and `result_valid` hold until the next accepted start or reset.

## Timing
- Start is accepted at edge T. `busy` and `sel`=first channel are visible from T+1.
- Each visited channel occupies SETTLE+1 cycles. `sel` is stable for that whole window, and the sample is taken on the final edge of the window.
- Full scan visits N=16 channels. The last capture occurs at edge T+N·(SETTLE+1).
- `done` is high for the cycle following that edge, with `result_valid` rising at the same edge.
- SETTLE=0: one channel per cycle; a full scan is 16 cycles.
- `mux_out` is treated as combinational from `sel`. The settle window covers the mux path delay, so no internal synchronizer is used.

## Configuration
- `MUX_SCAN_SKIP_EN` defined: channels with `mask_q[n]`=0 are skipped entirely. The next channel is the lowest enabled index above `ch`, and the masked `result` bits are 0. N equals the number of enabled channels.
  - If the mask is 0, start goes straight to DONE: `done` is high in the cycle after T, `result`=0, `result_valid`=1, and `busy` never rises.
- Not defined: all 16 channels are always visited and take 16·(SETTLE+1) cycles. Masked channels are still selected and timed, but their `result` bits are written 0.

## Test plan
- Full scan: SETTLE=2, mux sources=16'hA5C3, mask=16'hFFFF, start pulse → `sel` steps 0..15, each held 3 cycles; `done` pulses 48 cycles after T; `result`=16'hA5C3; `result_valid`=1.
- Masked scan: sources=16'hA5C3, mask=16'h00F0.
  - Without `MUX_SCAN_SKIP_EN`: `result`=16'h00C0, `done` at T+48.
  - With it: `sel` visits only 4..7, `result`=16'h00C0, `done` at T+12.
- Empty mask with `MUX_SCAN_SKIP_EN`: mask=0, start → `done` at T+1, `busy` stays 0, `result`=0, `result_valid`=1.
- Abort and busy start: start at T, start again at T+5 → ignored. abort at T+10 → `busy`=0 and `sel`=0 at T+11; no `done`; `result_valid`=0.
- Async reset mid-scan: rst_n low at T+20, asynchronous to clk → all outputs 0 immediately. A new start after release produces a correct full scan.
- Rescan: complete a scan with sources=16'hA5C3, change sources to 16'h1234, start again → `result_valid` drops at T+1; the second `done` has `result`=16'h1234.
